// File: rtl/alu_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding, default divider
// width and the step-counter width helper.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   localparam int DIV_W = 8;

   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/sub_div_sequencer_div_step.sv
// One restoring-division trial subtract: T = S - D, keep T unless it borrows.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   s_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             qbit_i,
   output logic [WIDTH-1:0] r_o,
   output logic             qbit_o,
   output logic             borrow_o
);

   logic [WIDTH:0] t;

   // qbit_i enables the step; a disabled step always restores.
   assign t        = s_i - {1'b0, d_i};
   assign borrow_o = t[WIDTH];
   assign qbit_o   = qbit_i & ~t[WIDTH];
   assign r_o      = qbit_o ? t[WIDTH-1:0] : s_i[WIDTH-1:0];

endmodule

// File: rtl/sub_div_sequencer.sv
// Multi-cycle unsigned restoring divider: one trial subtract per clock,
// valid/ready in and out, divide-by-zero short-cut straight to DONE.
module sub_div_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [1:0]       dbg_state_o,
   output logic             dbg_borrow_o
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // Handshake rule: a transfer happens on a rising edge where valid & ready
   // are both high; valid never waits on ready, ready depends only on state.

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   step_s;
   logic [WIDTH-1:0] step_r;
   logic             step_qbit;
   logic             step_borrow;
   logic [WIDTH-1:0] q_shift;

   assign step_s  = {r_q, q_q[WIDTH-1]};
   assign q_shift = {q_q[WIDTH-2:0], step_qbit};

   div_step #(.WIDTH(WIDTH)) u_step (
      .s_i      (step_s),
      .d_i      (d_q),
      .qbit_i   (state_q == ST_RUN),
      .r_o      (step_r),
      .qbit_o   (step_qbit),
      .borrow_o (step_borrow)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  q_d   = dividend;
                  d_d   = divisor;
                  r_d   = '0;
                  cnt_d = '0;
                  if (divisor == '0) begin
                     state_d = ST_DONE;
                     quo_d   = '1;
                     rem_d   = dividend;
                     dbz_d   = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               r_d   = step_r;
               q_d   = q_shift;
               cnt_d = cnt_q + 1'b1;
               // Results are latched on the final step so the outputs never show a partial value.
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_DONE;
                  quo_d   = q_shift;
                  rem_d   = step_r;
                  dbz_d   = 1'b0;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready     = (state_q == ST_IDLE);
   assign out_valid    = (state_q == ST_DONE);
   assign quotient     = quo_q;
   assign remainder    = rem_q;
   assign div_by_zero  = dbz_q;
   assign dbg_state_o  = state_q;
   assign dbg_borrow_o = step_borrow;

endmodule
